alu_multicycle: RTL and testbench

- Parametrised, multi-cycle successor to the 8-bit combinational ALU (FORWARD/ADD/AND/OR on DATA1, DATA2, SELECT, RESULT).
- Generalises operand width to WIDTH bits.
- Adds iterative multiply, shift and rotate operations, registered ZERO/OVERFLOW flags, and a START/BUSY/DONE handshake.
- Sits between the register file and the writeback mux of the CPU datapath; the control unit stalls on BUSY.

---
 rtl/alu_multicycle_if.sv | 25 ++
 rtl/alu_multicycle.sv | 167 ++++++++++++++++
 tb/tb_alu_multicycle.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/alu_multicycle_if.sv
// Handshake and operand/result bundle between the datapath and the multi-cycle ALU.
// The master drives the request; the slave (the ALU) returns result, flags and status.
interface alu_multicycle_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [2:0]       select;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, data1, data2, select,
    input  result, zero, overflow, busy, done
  );

  modport slave (
    input  start, data1, data2, select,
    output result, zero, overflow, busy, done
  );
endinterface

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-step FORWARD/ADD/AND/OR plus iterative MUL, SLL, SRA, ROR.
// Operands are latched on START in IDLE; one step is performed per clock in EXEC and
// RESULT/ZERO/OVERFLOW update only on the final step, together with a one-cycle DONE.
module alu_multicycle #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  alu_multicycle_if.slave bus
);
  localparam int CNTW = $clog2(WIDTH) + 1;
  localparam int LW   = $clog2(WIDTH);
  localparam logic [CNTW-1:0]  W_CNT  = CNTW'(WIDTH);
  localparam logic [WIDTH-1:0] W_DATA = WIDTH'(WIDTH);

  typedef enum logic [2:0] {
    OP_FWD = 3'b000,
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_MUL = 3'b100,
    OP_SLL = 3'b101,
    OP_SRA = 3'b110,
    OP_ROR = 3'b111
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  state_e           state_q, state_n;
  logic             busy;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [CNTW-1:0]  cnt_q;
  logic             amt_zero_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, ovf_q, done_q;

  logic [CNTW-1:0]  amt, load_cnt;
  logic [WIDTH-1:0] a_n, b_n, acc_n, res_n, sum;
  logic             ovf_n;
  logic             last_step;

  assign last_step = (cnt_q == CNTW'(1));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  // Next-state and BUSY decode.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    state_n = state_q;
    busy    = 1'b0;
    case (state_q)
      IDLE: if (bus.start) state_n = EXEC;
      EXEC: begin
        busy = 1'b1;
        if (last_step) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Step count for the incoming request: amounts are unsigned and clamped so the
  // counter never wraps; zero-amount shifts still take one (no-op) step.
  always_comb begin
    amt = '0;
    case (op_e'(bus.select))
      OP_SLL, OP_SRA: amt = (bus.data2 >= W_DATA) ? W_CNT : bus.data2[CNTW-1:0];
      OP_ROR:         amt = CNTW'(bus.data2[LW-1:0]);
      default:        amt = '0;
    endcase
    if (op_e'(bus.select) == OP_MUL) load_cnt = W_CNT;
    else                             load_cnt = (amt == '0) ? CNTW'(1) : amt;
  end

  // One EXEC step: next working values and the candidate result for the final step.
  always_comb begin
    a_n   = a_q;
    b_n   = b_q;
    acc_n = acc_q;
    res_n = '0;
    ovf_n = 1'b0;
    sum   = a_q + b_q;
    case (op_q)
      OP_FWD: res_n = b_q;
      OP_ADD: begin
        res_n = sum;
        ovf_n = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: res_n = a_q & b_q;
      OP_OR:  res_n = a_q | b_q;
      OP_MUL: begin
        if (b_q[0]) acc_n = acc_q + a_q;
        a_n   = a_q << 1;
        b_n   = b_q >> 1;
        res_n = acc_n;
      end
      OP_SLL: begin
        if (!amt_zero_q) a_n = {a_q[WIDTH-2:0], 1'b0};
        res_n = a_n;
      end
      OP_SRA: begin
        if (!amt_zero_q) a_n = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
        res_n = a_n;
      end
      OP_ROR: begin
        if (!amt_zero_q) a_n = {a_q[0], a_q[WIDTH-1:1]};
        res_n = a_n;
      end
      default: res_n = '0;
    endcase
  end

  // Operand latch, iteration registers and the architecturally visible result/flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= OP_FWD;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      amt_zero_q <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b1;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (bus.start) begin
          op_q       <= op_e'(bus.select);
          a_q        <= bus.data1;
          b_q        <= bus.data2;
          acc_q      <= '0;
          cnt_q      <= load_cnt;
          amt_zero_q <= (amt == '0);
        end
      end else begin
        a_q   <= a_n;
        b_q   <= b_n;
        acc_q <= acc_n;
        cnt_q <= cnt_q - 1'b1;
        if (last_step) begin
          result_q <= res_n;
          zero_q   <= (res_n == '0);
          ovf_q    <= ovf_n;
          done_q   <= 1'b1;
        end
      end
    end
  end

  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = busy;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: an 8-bit instance for the main test plan and a
// 16-bit instance for width generality. Inputs change 1 ns after a rising edge,
// outputs are sampled at that same point, well away from the next edge.
module tb_alu_multicycle;
  localparam logic [2:0] FWD = 3'b000, ADD = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                         MUL = 3'b100, SLL = 3'b101, SRA = 3'b110, ROR = 3'b111;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  alu_multicycle_if #(.WIDTH(8))  b8  ();
  alu_multicycle_if #(.WIDTH(16)) b16 ();

  alu_multicycle #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .bus(b8.slave));
  alu_multicycle #(.WIDTH(16)) u16 (.clk(clk), .reset(reset), .bus(b16.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and let edge k accept it; returns just after edge k.
  task automatic issue8(input logic [2:0] op, input logic [7:0] d1, input logic [7:0] d2);
    b8.select = op; b8.data1 = d1; b8.data2 = d2; b8.start = 1'b1;
    step();
    b8.start = 1'b0; b8.data1 = 8'hA5; b8.data2 = 8'h3C; b8.select = 3'b000;
  endtask

  task automatic issue16(input logic [2:0] op, input logic [15:0] d1, input logic [15:0] d2);
    b16.select = op; b16.data1 = d1; b16.data2 = d2; b16.start = 1'b1;
    step();
    b16.start = 1'b0;
  endtask

  // Wait (bounded) for DONE; e counts edges after edge k, bc counts BUSY cycles seen.
  task automatic wait8(input int e0, output int e, output int bc);
    e = e0; bc = 0;
    while (b8.done !== 1'b1 && e < 40) begin
      if (b8.busy === 1'b1) bc++;
      step();
      e++;
    end
  endtask

  task automatic wait16(output int e);
    e = 0;
    while (b16.done !== 1'b1 && e < 60) begin
      step();
      e++;
    end
  endtask

  task automatic run8(input string tag, input logic [2:0] op, input logic [7:0] d1,
                      input logic [7:0] d2, input int lat, input logic [7:0] res,
                      input logic z, input logic ov);
    int e, bc;
    issue8(op, d1, d2);
    wait8(0, e, bc);
    check({tag, " latency"}, e, lat);
    check({tag, " busy_cycles"}, bc, lat);
    check({tag, " busy_at_done"}, b8.busy, 1'b0);
    check({tag, " result"}, b8.result, res);
    check({tag, " zero"}, b8.zero, z);
    check({tag, " overflow"}, b8.overflow, ov);
  endtask

  initial begin
    int e, bc;
    bit saw_done;
    reset = 1'b1;
    b8.start = 1'b0;  b8.data1 = '0;  b8.data2 = '0;  b8.select = '0;
    b16.start = 1'b0; b16.data1 = '0; b16.data2 = '0; b16.select = '0;
    step(); step();
    check("rst result", b8.result, 8'h00);
    check("rst zero", b8.zero, 1'b1);
    check("rst overflow", b8.overflow, 1'b0);
    check("rst busy", b8.busy, 1'b0);
    check("rst done", b8.done, 1'b0);
    check("rst16 result", b16.result, 16'h0000);
    reset = 1'b0;
    step();

    // Single-step operations.
    run8("add_ff_01", ADD,  8'hFF, 8'h01, 1, 8'h00, 1'b1, 1'b0);
    run8("fwd_01",    FWD,  8'h77, 8'h01, 1, 8'h01, 1'b0, 1'b0);
    run8("add_32_3a", ADD,  8'h32, 8'h3A, 1, 8'h6C, 1'b0, 1'b0);
    run8("and",       AND_, 8'h32, 8'hC6, 1, 8'h02, 1'b0, 1'b0);
    run8("or",        OR_,  8'h32, 8'hC6, 1, 8'hF6, 1'b0, 1'b0);
    run8("add_ovf",   ADD,  8'h7F, 8'h01, 1, 8'h80, 1'b0, 1'b1);

    // Multiply: latency WIDTH, truncation.
    run8("mul_0d_0b", MUL, 8'h0D, 8'h0B, 8, 8'h8F, 1'b0, 1'b0);

    // START during EXEC must be ignored and RESULT must hold the previous value.
    issue8(MUL, 8'h14, 8'h14);
    step(); step();
    b8.select = ADD; b8.data1 = 8'h01; b8.data2 = 8'h01; b8.start = 1'b1;
    step();
    b8.start = 1'b0;
    check("mul_ign result_held", b8.result, 8'h8F);
    check("mul_ign busy", b8.busy, 1'b1);
    wait8(3, e, bc);
    check("mul_ign latency", e, 8);
    check("mul_ign result", b8.result, 8'h90);
    step();
    check("mul_ign no_second_op", b8.busy, 1'b0);

    // Shifts and rotate.
    run8("sra_90_3",   SRA, 8'h90, 8'd3,   3, 8'hF2, 1'b0, 1'b0);
    run8("sll_81_200", SLL, 8'h81, 8'd200, 8, 8'h00, 1'b1, 1'b0);
    run8("ror_81_9",   ROR, 8'h81, 8'd9,   1, 8'hC0, 1'b0, 1'b0);
    run8("sll_5a_0",   SLL, 8'h5A, 8'd0,   1, 8'h5A, 1'b0, 1'b0);
    run8("ror_5a_8",   ROR, 8'h5A, 8'd8,   1, 8'h5A, 1'b0, 1'b0);

    // Back-to-back issue with START held high.
    b8.select = ADD; b8.data1 = 8'h01; b8.data2 = 8'h01; b8.start = 1'b1;
    step();                                   // edge k
    b8.select = OR_; b8.data1 = 8'hF0; b8.data2 = 8'h0F;
    step();                                   // edge k+1
    check("b2b done1", b8.done, 1'b1);
    check("b2b result1", b8.result, 8'h02);
    step();                                   // edge k+2: second op accepted
    b8.start = 1'b0;
    check("b2b busy2", b8.busy, 1'b1);
    check("b2b done_low", b8.done, 1'b0);
    step();                                   // edge k+3
    check("b2b done2", b8.done, 1'b1);
    check("b2b result2", b8.result, 8'hFF);
    step();

    // Reset in the middle of a multiply.
    issue8(MUL, 8'h0D, 8'h0B);
    step(); step(); step();
    reset = 1'b1;
    step();                                   // edge k+4
    reset = 1'b0;
    check("rstmid busy", b8.busy, 1'b0);
    check("rstmid done", b8.done, 1'b0);
    check("rstmid result", b8.result, 8'h00);
    check("rstmid zero", b8.zero, 1'b1);
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (b8.done === 1'b1) saw_done = 1'b1;
      step();
    end
    check("rstmid no_done", saw_done, 1'b0);
    run8("add_after_rst", ADD, 8'h02, 8'h03, 1, 8'h05, 1'b0, 1'b0);

    // Width generality on the 16-bit instance.
    issue16(MUL, 16'h0100, 16'h0100);
    wait16(e);
    check("w16 mul latency", e, 16);
    check("w16 mul result", b16.result, 16'h0000);
    check("w16 mul zero", b16.zero, 1'b1);
    issue16(SRA, 16'h8000, 16'd15);
    wait16(e);
    check("w16 sra latency", e, 15);
    check("w16 sra result", b16.result, 16'hFFFF);
    check("w16 sra zero", b16.zero, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
